sprite_motion_ctrl: RTL and testbench

//   Frame-driven motion engine for NUM_SPRITES sprites; generalises single-sprite bounce logic.

---
 rtl/sprite_motion_ctrl.sv | 158 +++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// Frame-driven bounce engine for NUM_SPRITES sprites. Runs on the pixel clock and
// edge-detects vert sync, updating one sprite per cycle every FRAME_DIV frames.
module sprite_motion_ctrl #(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = 16,
  parameter int MAX_X       = 800,
  parameter int MAX_Y       = 150,
  parameter int FRAME_DIV   = 8,
  parameter int INIT_X_VEL  = 2,
  parameter int INIT_Y_VEL  = 0,
  localparam int IDX_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                             i_pix_clk,
  input  logic                             i_reset,
  input  logic                             i_vert_sync,
  input  logic                             i_load_valid,
  output logic                             o_load_ready,
  input  logic [IDX_W-1:0]                 i_load_idx,
  input  logic signed [COORD_W-1:0]        i_load_x,
  input  logic signed [COORD_W-1:0]        i_load_y,
  input  logic signed [COORD_W-1:0]        i_load_xv,
  input  logic signed [COORD_W-1:0]        i_load_yv,
  output logic [NUM_SPRITES*COORD_W-1:0]   o_spr_x,
  output logic [NUM_SPRITES*COORD_W-1:0]   o_spr_y,
  output logic [NUM_SPRITES-1:0]           o_bounce,
  output logic                             o_done,
  output logic                             o_overrun
);

  localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(NUM_SPRITES - 1);
  localparam logic [FC_W-1:0]           FC_LAST  = FC_W'(FRAME_DIV - 1);
  localparam logic signed [COORD_W:0]   LIM_X    = (COORD_W+1)'(MAX_X);
  localparam logic signed [COORD_W:0]   LIM_Y    = (COORD_W+1)'(MAX_Y);
  localparam logic signed [COORD_W-1:0] HI_X     = COORD_W'(MAX_X - 1);
  localparam logic signed [COORD_W-1:0] HI_Y     = COORD_W'(MAX_Y - 1);
  localparam logic signed [COORD_W-1:0] INIT_XV  = COORD_W'(INIT_X_VEL);
  localparam logic signed [COORD_W-1:0] INIT_YV  = COORD_W'(INIT_Y_VEL);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  typedef struct packed {
    logic                      hit;
    logic signed [COORD_W-1:0] vel;
    logic signed [COORD_W-1:0] pos;
  } axis_t;

  // One extra bit on the sum keeps pos+vel exact, so the bound tests never see a wrapped value.
  function automatic axis_t axis_step(input logic signed [COORD_W-1:0] pos,
                                      input logic signed [COORD_W-1:0] vel,
                                      input logic signed [COORD_W:0]   lim,
                                      input logic signed [COORD_W-1:0] clamp_hi);
    logic signed [COORD_W:0] nxt;
    axis_t r;
    nxt   = $signed({pos[COORD_W-1], pos}) + $signed({vel[COORD_W-1], vel});
    r.hit = 1'b0;
    r.vel = vel;
    r.pos = nxt[COORD_W-1:0];
    if (vel != '0) begin
      if (nxt >= lim) begin
        r.hit = 1'b1;
        r.vel = -vel;
        r.pos = clamp_hi;
      end else if (nxt[COORD_W]) begin
        r.hit = 1'b1;
        r.vel = -vel;
        r.pos = '0;
      end
    end
    return r;
  endfunction

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic [FC_W-1:0]           frame_cnt;
  logic                      vsync_d;
  logic signed [COORD_W-1:0] pos_x [NUM_SPRITES];
  logic signed [COORD_W-1:0] pos_y [NUM_SPRITES];
  logic signed [COORD_W-1:0] vel_x [NUM_SPRITES];
  logic signed [COORD_W-1:0] vel_y [NUM_SPRITES];

  logic  vs_edge, frame_wrap, trigger, load_fire;
  axis_t ax, ay;

  assign vs_edge      = i_vert_sync & ~vsync_d;
  assign frame_wrap   = (frame_cnt == FC_LAST);
  assign trigger      = vs_edge & frame_wrap;
  assign o_load_ready = (state == S_IDLE);
  assign load_fire    = i_load_valid && o_load_ready &&
                        ({1'b0, i_load_idx} < (IDX_W+1)'(NUM_SPRITES));

  always_comb begin
    ax = axis_step(pos_x[idx], vel_x[idx], LIM_X, HI_X);
    ay = axis_step(pos_y[idx], vel_y[idx], LIM_Y, HI_Y);
  end

  always_comb begin
    o_spr_x = '0;
    o_spr_y = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      o_spr_x[i*COORD_W +: COORD_W] = pos_x[i];
      o_spr_y[i*COORD_W +: COORD_W] = pos_y[i];
    end
  end

  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      frame_cnt <= '0;
      vsync_d   <= 1'b0;
      o_bounce  <= '0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pos_x[i] <= '0;
        pos_y[i] <= '0;
        vel_x[i] <= INIT_XV;
        vel_y[i] <= INIT_YV;
      end
    end else begin
      vsync_d   <= i_vert_sync;
      o_done    <= 1'b0;
      o_overrun <= trigger && (state != S_IDLE);
      if (vs_edge) frame_cnt <= frame_wrap ? '0 : FC_W'(frame_cnt + 1'b1);
      case (state)
        S_IDLE: begin
          if (load_fire) begin
            pos_x[i_load_idx] <= i_load_x;
            pos_y[i_load_idx] <= i_load_y;
            vel_x[i_load_idx] <= i_load_xv;
            vel_y[i_load_idx] <= i_load_yv;
          end
          if (trigger) begin
            idx      <= '0;
            o_bounce <= '0;
            state    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          pos_x[idx] <= ax.pos;
          vel_x[idx] <= ax.vel;
          pos_y[idx] <= ay.pos;
          vel_y[idx] <= ay.vel;
          if (ax.hit || ay.hit) o_bounce[idx] <= 1'b1;
          if (idx == LAST_IDX) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: one 4-sprite/FRAME_DIV=8 instance and one
// 5-sprite/FRAME_DIV=1 instance sharing clock and reset.
module tb_sprite_motion_ctrl;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                vs8 = 1'b0, lv8 = 1'b0;
  logic [1:0]          li8 = '0;
  logic signed [W-1:0] lx8 = '0, ly8 = '0, lxv8 = '0, lyv8 = '0;
  logic                rdy8, dn8, ov8;
  logic [4*W-1:0]      sx8, sy8;
  logic [3:0]          b8;

  logic                vs1 = 1'b0, lv1 = 1'b0;
  logic [2:0]          li1 = '0;
  logic signed [W-1:0] lx1 = '0, ly1 = '0, lxv1 = '0, lyv1 = '0;
  logic                rdy1, dn1, ov1;
  logic [5*W-1:0]      sx1, sy1;
  logic [4:0]          b1;

  sprite_motion_ctrl #(.NUM_SPRITES(4), .COORD_W(W), .FRAME_DIV(8)) dut8 (
    .i_pix_clk(clk), .i_reset(rst), .i_vert_sync(vs8),
    .i_load_valid(lv8), .o_load_ready(rdy8), .i_load_idx(li8),
    .i_load_x(lx8), .i_load_y(ly8), .i_load_xv(lxv8), .i_load_yv(lyv8),
    .o_spr_x(sx8), .o_spr_y(sy8), .o_bounce(b8), .o_done(dn8), .o_overrun(ov8));

  sprite_motion_ctrl #(.NUM_SPRITES(5), .COORD_W(W), .FRAME_DIV(1)) dut1 (
    .i_pix_clk(clk), .i_reset(rst), .i_vert_sync(vs1),
    .i_load_valid(lv1), .o_load_ready(rdy1), .i_load_idx(li1),
    .i_load_x(lx1), .i_load_y(ly1), .i_load_xv(lxv1), .i_load_yv(lyv1),
    .o_spr_x(sx1), .o_spr_y(sy1), .o_bounce(b1), .o_done(dn1), .o_overrun(ov1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [31:0] x8(input int i);
    logic signed [W-1:0] t;
    t = sx8[i*W +: W];
    return 32'(t);
  endfunction
  function automatic logic signed [31:0] y8(input int i);
    logic signed [W-1:0] t;
    t = sy8[i*W +: W];
    return 32'(t);
  endfunction
  function automatic logic signed [31:0] x1(input int i);
    logic signed [W-1:0] t;
    t = sx1[i*W +: W];
    return 32'(t);
  endfunction
  function automatic logic signed [31:0] y1(input int i);
    logic signed [W-1:0] t;
    t = sy1[i*W +: W];
    return 32'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Eight vsync edges on dut8; optional load presented in the triggering cycle.
  task automatic frame8(input bit ld, output int lat, output int dones);
    dones = 0;
    lat   = -1;
    for (int k = 0; k < 7; k++) begin
      vs8 = 1'b1; tick(); if (dn8) dones++;
      vs8 = 1'b0; tick(); if (dn8) dones++;
    end
    vs8 = 1'b1;
    if (ld) lv8 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      vs8 = 1'b0;
      lv8 = 1'b0;
      if (dn8) begin
        dones++;
        if (lat < 0) lat = c;
      end
    end
  endtask

  task automatic frame1(output int lat, output int dones);
    dones = 0;
    lat   = -1;
    vs1   = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      vs1 = 1'b0;
      if (dn1) begin
        dones++;
        if (lat < 0) lat = c;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, dones;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    for (int i = 0; i < 4; i++) check("rst_x", x8(i), 0);
    check("rst_y0", y8(0), 0);
    check("rst_bounce", 32'(b8), 0);
    check("rst_done", 32'(dn8), 0);
    check("rst_overrun", 32'(ov8), 0);
    check("rst_ready", 32'(rdy8), 1);

    // first update after eight edges
    frame8(1'b0, lat, dones);
    check("f1_latency", lat, 5);
    check("f1_done_count", dones, 1);
    for (int i = 0; i < 4; i++) check("f1_x", x8(i), 2);
    for (int i = 0; i < 4; i++) check("f1_y", y8(i), 0);
    check("f1_bounce", 32'(b8), 0);

    // right-edge bounce on sprite 1
    li8 = 2'd1; lx8 = 798; ly8 = 0; lxv8 = 3; lyv8 = 0; lv8 = 1'b1;
    tick();
    lv8 = 1'b0;
    check("load1_x", x8(1), 798);
    frame8(1'b0, lat, dones);
    check("f2_x1_clamp", x8(1), 799);
    check("f2_bounce", 32'(b8), 2);
    check("f2_x0", x8(0), 4);
    frame8(1'b0, lat, dones);
    check("f3_x1_reversed", x8(1), 796);
    check("f3_bounce_cleared", 32'(b8), 0);
    check("f3_x0", x8(0), 6);

    // top-edge bounce on sprite 2
    li8 = 2'd2; lx8 = 100; ly8 = 1; lxv8 = 0; lyv8 = -5; lv8 = 1'b1;
    tick();
    lv8 = 1'b0;
    check("load2_y", y8(2), 1);
    frame8(1'b0, lat, dones);
    check("f4_y2_clamp", y8(2), 0);
    check("f4_bounce", 32'(b8), 4);
    check("f4_x2_static", x8(2), 100);
    check("f4_x1", x8(1), 793);

    // load and trigger in the same cycle: load lands before the update
    li8 = 2'd0; lx8 = 50; ly8 = 0; lxv8 = 1; lyv8 = 0;
    frame8(1'b1, lat, dones);
    check("f5_latency", lat, 5);
    check("f5_x0_load_then_step", x8(0), 51);
    check("f5_y2_reversed", y8(2), 5);
    check("f5_x3", x8(3), 10);
    check("f5_x1", x8(1), 790);
    check("f5_bounce", 32'(b8), 0);

    // out-of-range load index on the 5-sprite instance
    li1 = 3'd5; lx1 = 123; ly1 = 45; lxv1 = 7; lyv1 = 9; lv1 = 1'b1;
    tick();
    check("bad_idx_ready", 32'(rdy1), 1);
    lv1 = 1'b0;
    for (int i = 0; i < 5; i++) check("bad_idx_x", x1(i), 0);
    for (int i = 0; i < 5; i++) check("bad_idx_y", y1(i), 0);
    frame1(lat, dones);
    check("d1_latency", lat, 6);
    for (int i = 0; i < 5; i++) check("d1_x", x1(i), 2);
    check("d1_y4", y1(4), 0);

    // trigger while busy is dropped and flagged
    dones = 0;
    vs1 = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (dn1) dones++;
      if (c == 1) vs1 = 1'b0;
      if (c == 2) vs1 = 1'b1;
      if (c == 3) begin
        check("overrun_pulse", 32'(ov1), 1);
        vs1 = 1'b0;
      end
      if (c == 4) check("overrun_single", 32'(ov1), 0);
    end
    check("overrun_done_count", dones, 1);
    check("overrun_x0", x1(0), 4);
    check("overrun_x4", x1(4), 4);

    // reset two cycles into an update
    vs1 = 1'b1;
    tick();
    vs1 = 1'b0;
    tick();
    check("mid_x0_updated", x1(0), 6);
    tick();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) check("midrst_x", x1(i), 0);
    check("midrst_ready", 32'(rdy1), 1);
    check("midrst_done", 32'(dn1), 0);
    tick();
    rst = 1'b0;
    tick();
    frame1(lat, dones);
    check("post_rst_latency", lat, 6);
    check("post_rst_x0", x1(0), 2);
    check("post_rst_x4", x1(4), 2);
    check("post_rst_y0", y1(0), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
